// File: rtl/pkt_rx_pkg.sv
// Shared types and constants for the packet decoder.
package pkt_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StCheck,
    StCommit
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int unsigned MAX_BYTES_DEFAULT      = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/hex_to_ascii.sv
// Converts one nibble to its uppercase ASCII hex digit.
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      ascii = 8'h37 + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/packet_decoder.sv
// Length/payload/checksum frame decoder feeding a double-buffered hex display.
// Optional inter-byte timeout compiled in with RX_TIMEOUT_EN.
module packet_decoder
  import pkt_rx_pkg::*;
#(
  parameter int unsigned MAX_BYTES      = MAX_BYTES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       iCLK,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [4:0] char_sel,
  output logic [7:0] char_out,
  output logic       frame_done,
  output logic       frame_err,
  output logic [4:0] byte_count
);

  localparam int unsigned NumChars = 2 * MAX_BYTES;
  localparam logic [7:0]  MaxLen   = 8'(MAX_BYTES);

  state_t     state_q, state_d;
  logic [7:0] len_q;
  logic [7:0] idx_q;
  logic [7:0] xor_q;
  logic [7:0] shadow_q [NumChars];
  logic [7:0] commit_q [NumChars];

  logic       accept;
  logic       load_len, wr_payload, do_commit;
  logic       done_d, err_d;
  logic       tmo_hit;
  logic [7:0] hi_char, lo_char;

  assign accept     = byte_valid & byte_ready;
  assign byte_ready = (state_q != StCommit);

  hex_to_ascii u_hex_hi (
    .nibble (byte_in[7:4]),
    .ascii  (hi_char)
  );

  hex_to_ascii u_hex_lo (
    .nibble (byte_in[3:0]),
    .ascii  (lo_char)
  );

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;

  assign tmo_hit = ((state_q == StPayload) || (state_q == StCheck)) &&
                   (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iCLK or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (accept || tmo_hit) begin
      tmo_q <= '0;
    end else if ((state_q == StPayload) || (state_q == StCheck)) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    load_len   = 1'b0;
    wr_payload = 1'b0;
    do_commit  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if ((byte_in != 8'd0) && (byte_in <= MaxLen)) begin
            load_len = 1'b1;
            state_d  = StPayload;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StPayload: begin
        if (accept) begin
          wr_payload = 1'b1;
          if (idx_q == len_q - 8'd1) state_d = StCheck;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCheck: begin
        if (accept) begin
          if (byte_in == xor_q) begin
            state_d = StCommit;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCommit: begin
        do_commit = 1'b1;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge iCLK or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      byte_count <= '0;
      for (int i = 0; i < NumChars; i++) begin
        shadow_q[i] <= ASCII_SPACE;
        commit_q[i] <= ASCII_SPACE;
      end
    end else begin
      frame_done <= done_d;
      frame_err  <= err_d;
      if (load_len) begin
        len_q <= byte_in;
        idx_q <= '0;
        xor_q <= byte_in;
        for (int i = 0; i < NumChars; i++) shadow_q[i] <= ASCII_SPACE;
      end
      if (wr_payload) begin
        xor_q <= xor_q ^ byte_in;
        idx_q <= idx_q + 8'd1;
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (idx_q == 8'(i)) begin
            shadow_q[2*i]   <= hi_char;
            shadow_q[2*i+1] <= lo_char;
          end
        end
      end
      // The display only ever sees whole, checksum-verified frames.
      if (do_commit) begin
        byte_count <= 5'(len_q);
        for (int i = 0; i < NumChars; i++) commit_q[i] <= shadow_q[i];
      end
    end
  end

  always_comb begin
    char_out = ASCII_SPACE;
    for (int i = 0; i < NumChars; i++) begin
      if (char_sel == 5'(i)) char_out = commit_q[i];
    end
  end

endmodule

// File: tb/tb_packet_decoder.sv
// Table-driven frame checks plus hand sequences for reset, back-to-back and timeout cases.
module tb_packet_decoder;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TbTmo = 16;
`else
  localparam int unsigned TbTmo = 1000000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [4:0] char_sel;
  logic [7:0] char_out;
  logic       frame_done;
  logic       frame_err;
  logic [4:0] byte_count;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  packet_decoder #(
    .MAX_BYTES      (16),
    .TIMEOUT_CYCLES (TbTmo)
  ) dut (
    .iCLK       (clk),
    .rst        (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .char_sel   (char_sel),
    .char_out   (char_out),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .byte_count (byte_count)
  );

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (frame_done && frame_err) both_cnt++;
  end

  typedef struct {
    int          first;
    int          n;
    int          exp_done;
    int          exp_err;
    int          exp_count;
    logic [39:0] exp_str;   // chars 0..4, char 0 in the top byte
    logic [7:0]  exp_c31;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] stream[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int tries;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    tries = 0;
    while (!byte_ready && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    if (tries == 8) check("byte_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic read_char(input int idx, output int c);
    char_sel = 5'(idx);
    #1;
    c = int'(char_out);
  endtask

  task automatic check_chars(input string tag, input logic [39:0] s, input logic [7:0] c31);
    int c;
    for (int k = 0; k < 5; k++) begin
      read_char(k, c);
      check($sformatf("%s_char%0d", tag, k), c, int'(s[8*(4-k) +: 8]));
    end
    read_char(31, c);
    check($sformatf("%s_char31", tag), c, int'(c31));
  endtask

  task automatic add_vec(input int first, input int de, input int ee, input int cnt,
                         input logic [39:0] s, input logic [7:0] c31);
    vec_t v;
    v.first = first; v.n = stream.size() - first;
    v.exp_done = de; v.exp_err = ee; v.exp_count = cnt;
    v.exp_str = s; v.exp_c31 = c31;
    vecs.push_back(v);
  endtask

  initial begin
    int f, d0, e0, b0, c;
    rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    char_sel   = 5'd0;

    // Good two-byte frame.
    f = stream.size();
    stream.push_back(8'h02); stream.push_back(8'h3C); stream.push_back(8'hA5);
    stream.push_back(8'h9B);
    add_vec(f, 1, 0, 2, "3CA5 ", 8'h20);
    // Bad checksum leaves the previous display intact.
    f = stream.size();
    stream.push_back(8'h01); stream.push_back(8'hFF); stream.push_back(8'h00);
    add_vec(f, 0, 1, 2, "3CA5 ", 8'h20);
    // Zero and oversize lengths.
    f = stream.size(); stream.push_back(8'h00);
    add_vec(f, 0, 1, 2, "3CA5 ", 8'h20);
    f = stream.size(); stream.push_back(8'h11);
    add_vec(f, 0, 1, 2, "3CA5 ", 8'h20);
    // Shorter frame clears the tail to spaces.
    f = stream.size();
    stream.push_back(8'h01); stream.push_back(8'h0F); stream.push_back(8'h0E);
    add_vec(f, 1, 0, 1, "0F   ", 8'h20);
    f = stream.size();
    stream.push_back(8'h03); stream.push_back(8'h12); stream.push_back(8'h34);
    stream.push_back(8'hAB); stream.push_back(8'h8E);
    add_vec(f, 1, 0, 3, "1234A", 8'h20);
    // Full MAX_BYTES frame: payload 00..0F XORs to 0, so checksum is the length.
    f = stream.size();
    stream.push_back(8'h10);
    for (int i = 0; i < 16; i++) stream.push_back(8'(i));
    stream.push_back(8'h10);
    add_vec(f, 1, 0, 16, "00010", 8'h46);

    // Reset state.
    #12;
    check("rst_ready", int'(byte_ready), 1);
    check("rst_count", int'(byte_count), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_err", int'(frame_err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", int'(byte_ready), 1);
    check_chars("rst", "     ", 8'h20);

    foreach (vecs[i]) begin
      d0 = done_cnt; e0 = err_cnt; b0 = both_cnt;
      for (int j = 0; j < vecs[i].n; j++) send(stream[vecs[i].first + j]);
      idle(4);
      check($sformatf("v%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("v%0d_both", i), both_cnt - b0, 0);
      check($sformatf("v%0d_count", i), int'(byte_count), vecs[i].exp_count);
      check_chars($sformatf("v%0d", i), vecs[i].exp_str, vecs[i].exp_c31);
    end

    // Reset mid-frame, then a fresh frame.
    send(8'h04); send(8'hAA); send(8'hBB);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_count", int'(byte_count), 0);
    check("midrst_done", int'(frame_done), 0);
    check("midrst_err", int'(frame_err), 0);
    check_chars("midrst", "     ", 8'h20);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    send(8'h01); send(8'h0F); send(8'h0E);
    idle(4);
    check("postrst_done", done_cnt - d0, 1);
    check("postrst_count", int'(byte_count), 1);
    check_chars("postrst", "0F   ", 8'h20);

    // byte_valid held high across COMMIT: the byte offered there must wait.
    @(negedge clk); byte_valid = 1'b1; byte_in = 8'h02;
    @(negedge clk); byte_in = 8'h3C;
    @(negedge clk); byte_in = 8'hA5;
    @(negedge clk); byte_in = 8'h9B;
    @(negedge clk); byte_in = 8'h01;
    check("commit_ready", int'(byte_ready), 0);
    check("commit_done_early", int'(frame_done), 0);
    @(negedge clk);
    check("done_latency", int'(frame_done), 1);
    check("ready_after_commit", int'(byte_ready), 1);
    @(negedge clk); byte_in = 8'h0F;
    @(negedge clk); byte_in = 8'h0E;
    @(negedge clk); byte_valid = 1'b0;
    idle(3);
    check("b2b_count", int'(byte_count), 1);
    check_chars("b2b", "0F   ", 8'h20);

`ifdef RX_TIMEOUT_EN
    e0 = err_cnt;
    send(8'h03); send(8'h11);
    idle(40);
    check("tmo_err", err_cnt - e0, 1);
    d0 = done_cnt;
    send(8'h02); send(8'h3C); send(8'hA5); send(8'h9B);
    idle(4);
    check("tmo_next_done", done_cnt - d0, 1);
    check_chars("tmo_next", "3CA5 ", 8'h20);
`endif

    read_char(0, c);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
